// File: rtl/vga_frame_capture.sv
// Captures one active VGA frame, converted to 8-bit luma, into a pixel-memory write port.
// VGA_CLK is sampled as data in the system clock domain; decisions happen only on its rising edge.
module vga_frame_capture #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              arm,
  input  logic              abort,
  input  logic              VGA_CLK,
  input  logic              VGA_HS,
  input  logic              VGA_VS,
  input  logic              VGA_BLANK_n,
  input  logic [7:0]        VGA_R,
  input  logic [7:0]        VGA_G,
  input  logic [7:0]        VGA_B,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              done,
  output logic              line_err,
  output logic              frame_err,
  output logic [9:0]        lines_captured
);

  localparam int unsigned XW = $clog2(H_ACTIVE + 2);
  localparam int unsigned YW = $clog2(V_ACTIVE + 1);
  localparam logic [XW-1:0]     XAct     = XW'(H_ACTIVE);
  localparam logic [XW-1:0]     XSat     = XW'(H_ACTIVE + 1);
  localparam logic [YW-1:0]     YAct     = YW'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] LineStep = ADDR_W'(H_ACTIVE);

  typedef enum logic [1:0] {StIdle, StWaitVs, StCapture, StDone} state_e;

  logic       vclk_q, vclk_prev_q, hs_q, vs_q, blank_q;
  logic [7:0] r_q, g_q, b_q;

  state_e            state_q, state_d;
  logic              seen_vs_q, seen_vs_d;
  logic              blank_prev_q, blank_prev_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [YW-1:0]     y_inc;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              line_err_q, line_err_d;
  logic              frame_err_q, frame_err_d;
  logic [9:0]        lines_q, lines_d;

  logic       ps;
  logic [9:0] luma_sum;
  logic [7:0] luma;
  logic       unused_hs;

  // Sync is carried through the input stage but framing relies on VS and BLANK_n only.
  assign unused_hs = hs_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vclk_q      <= 1'b0;
      vclk_prev_q <= 1'b0;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      blank_q     <= 1'b0;
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
    end else begin
      vclk_q      <= VGA_CLK;
      vclk_prev_q <= vclk_q;
      hs_q        <= VGA_HS;
      vs_q        <= VGA_VS;
      blank_q     <= VGA_BLANK_n;
      r_q         <= VGA_R;
      g_q         <= VGA_G;
      b_q         <= VGA_B;
    end
  end

  assign ps       = vclk_q & ~vclk_prev_q;
  assign luma_sum = {2'b00, r_q} + {1'b0, g_q, 1'b0} + {2'b00, b_q};
  assign luma     = 8'(luma_sum >> 2);
  assign y_inc    = y_q + YW'(1);

  always_comb begin
    state_d      = state_q;
    seen_vs_d    = seen_vs_q;
    blank_prev_d = ps ? blank_q : blank_prev_q;
    x_d          = x_q;
    y_d          = y_q;
    addr_d       = addr_q;
    base_d       = base_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    line_err_d   = line_err_q;
    frame_err_d  = frame_err_q;
    lines_d      = lines_q;

    case (state_q)
      StIdle, StDone: begin
        if (arm && !abort) begin
          state_d     = StWaitVs;
          seen_vs_d   = 1'b0;
          line_err_d  = 1'b0;
          frame_err_d = 1'b0;
          lines_d     = '0;
        end
      end
      StWaitVs: begin
        if (abort) begin
          state_d = StIdle;
        end else if (ps) begin
          if (!vs_q) begin
            seen_vs_d = 1'b1;
          end else if (seen_vs_q) begin
            // Only the trailing edge of a vsync we actually observed starts a frame.
            state_d = StCapture;
            x_d     = '0;
            y_d     = '0;
            addr_d  = '0;
            base_d  = '0;
          end
        end
      end
      StCapture: begin
        if (abort) begin
          state_d = StIdle;
        end else if (ps) begin
          if (!vs_q) begin
            frame_err_d = 1'b1;
            state_d     = StDone;
          end else if (blank_q) begin
            if (x_q < XAct) begin
              wr_en_d   = 1'b1;
              wr_addr_d = addr_q;
              wr_data_d = luma;
              addr_d    = addr_q + ADDR_W'(1);
            end
            if (x_q != XSat) begin
              x_d = x_q + XW'(1);
            end
          end else if (blank_prev_q) begin
            if (x_q != XAct) begin
              line_err_d = 1'b1;
            end
            y_d     = y_inc;
            lines_d = 10'(y_inc);
            x_d     = '0;
            // Each line starts at a fixed slot, so a short or long line cannot shift the next.
            base_d  = base_q + LineStep;
            addr_d  = base_q + LineStep;
            if (y_inc == YAct) begin
              state_d = StDone;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      seen_vs_q    <= 1'b0;
      blank_prev_q <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      addr_q       <= '0;
      base_q       <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      line_err_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      lines_q      <= '0;
    end else begin
      state_q      <= state_d;
      seen_vs_q    <= seen_vs_d;
      blank_prev_q <= blank_prev_d;
      x_q          <= x_d;
      y_q          <= y_d;
      addr_q       <= addr_d;
      base_q       <= base_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      line_err_q   <= line_err_d;
      frame_err_q  <= frame_err_d;
      lines_q      <= lines_d;
    end
  end

  assign wr_en          = wr_en_q;
  assign wr_addr        = wr_addr_q;
  assign wr_data        = wr_data_q;
  assign busy           = (state_q == StWaitVs) || (state_q == StCapture);
  assign done           = (state_q == StDone);
  assign line_err       = line_err_q;
  assign frame_err      = frame_err_q;
  assign lines_captured = lines_q;

endmodule

// File: tb/tb_vga_frame_capture.sv
// Bench for vga_frame_capture: drives a reduced-size VGA timing model; a frame-level model
// queues expected writes and flag values, and a separate monitor scores every wr_en.
module tb_vga_frame_capture;

  localparam int H  = 16;
  localparam int V  = 6;
  localparam int HB = 6;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          arm = 1'b0;
  logic          abort = 1'b0;
  logic          vga_clk = 1'b1;
  logic          vga_hs = 1'b1;
  logic          vga_vs = 1'b1;
  logic          vga_blank = 1'b0;
  logic [7:0]    vga_r = '0;
  logic [7:0]    vga_g = '0;
  logic [7:0]    vga_b = '0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          busy;
  logic          done;
  logic          line_err;
  logic          frame_err;
  logic [9:0]    lines_captured;

  vga_frame_capture #(
    .H_ACTIVE(H),
    .V_ACTIVE(V),
    .ADDR_W  (AW)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .arm           (arm),
    .abort         (abort),
    .VGA_CLK       (vga_clk),
    .VGA_HS        (vga_hs),
    .VGA_VS        (vga_vs),
    .VGA_BLANK_n   (vga_blank),
    .VGA_R         (vga_r),
    .VGA_G         (vga_g),
    .VGA_B         (vga_b),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .busy          (busy),
    .done          (done),
    .line_err      (line_err),
    .frame_err     (frame_err),
    .lines_captured(lines_captured)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_err = 0;

  // Frame-level reference model state.
  bit  cap_on = 0;
  bit  cap_pending = 0;
  bit  m_done = 0;
  bit  m_lerr = 0;
  bit  m_ferr = 0;
  int  m_lines = 0;
  int  cmode = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every write must match the head of the expected queue.
  initial begin
    wr_t e;
    bit  wr_prev;
    wr_prev = 0;
    forever begin
      @(negedge clk);
      if (wr_en) begin
        check("wr_en_back_to_back", int'(wr_prev), 0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_write: addr %0d data %0d, no write expected",
                   wr_addr, wr_data);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", int'(wr_addr), e.addr);
          check("wr_data", int'(wr_data), e.data);
        end
      end
      wr_prev = wr_en;
    end
  end

  task automatic drive_px(input bit vs, input bit hs, input bit blank,
                          input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    @(posedge clk); #1;
    vga_clk = 1'b0;
    vga_vs = vs;
    vga_hs = hs;
    vga_blank = blank;
    vga_r = r;
    vga_g = g;
    vga_b = b;
    repeat ($urandom_range(0, 1)) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    vga_clk = 1'b1;
  endtask

  task automatic check_outputs_zero();
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_wr_addr", int'(wr_addr), 0);
    check("rst_wr_data", int'(wr_data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_line_err", int'(line_err), 0);
    check("rst_frame_err", int'(frame_err), 0);
    check("rst_lines", int'(lines_captured), 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check_outputs_zero();
    exp_q.delete();
    cap_on = 0;
    cap_pending = 0;
    m_done = 0;
    m_lerr = 0;
    m_ferr = 0;
    m_lines = 0;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic pulse(input bit a, input bit b);
    @(posedge clk); #1;
    arm = a;
    abort = b;
    if (b) begin
      cap_on = 0;
      cap_pending = 0;
    end else if (a && !(cap_on || cap_pending)) begin
      cap_pending = 1;
      m_done = 0;
      m_lerr = 0;
      m_ferr = 0;
      m_lines = 0;
    end
    @(posedge clk); #1;
    arm = 1'b0;
    abort = 1'b0;
    check("busy_after_pulse", int'(busy), int'(cap_on || cap_pending));
  endtask

  task automatic drive_line(input int n_act, input bit vs, input int reset_col);
    logic [7:0] r, g, b;
    int         cidx;
    for (int c = 0; c < n_act; c++) begin
      if (c == reset_col) do_reset();
      cidx = c;
      case (cmode)
        1: begin r = cidx[7:0]; g = cidx[7:0]; b = cidx[7:0]; end
        2: begin r = 8'd255; g = 8'd0; b = 8'd0; end
        3: begin r = 8'd10; g = 8'd20; b = 8'd30; end
        default: begin r = 8'($urandom); g = 8'($urandom); b = 8'($urandom); end
      endcase
      if (cap_on) begin
        exp_q.push_back(wr_t'{addr: m_lines * H + c,
                              data: (int'(r) + 2 * int'(g) + int'(b)) / 4});
      end
      drive_px(1'b1, 1'b1, 1'b1, r, g, b);
    end
    if (n_act > 0 && cap_on) begin
      if (n_act != H) m_lerr = 1;
      m_lines++;
      if (m_lines == V) begin
        m_done = 1;
        cap_on = 0;
      end
    end
    for (int c = 0; c < HB + ((n_act == 0) ? H : 0); c++) begin
      if (!vs && cap_on) begin
        m_ferr = 1;
        m_done = 1;
        cap_on = 0;
      end
      drive_px(vs, !(c >= 1 && c < 3), 1'b0, 8'd0, 8'd0, 8'd0);
    end
  endtask

  // Frame order: vsync, back porch, active rows, front porch.
  task automatic drive_frame(input int short_row, input int vs_row, input int arm_row,
                             input int abort_row, input int reset_row);
    drive_line(0, 1'b0, -1);
    drive_line(0, 1'b0, -1);
    if (cap_pending) begin
      cap_on = 1;
      cap_pending = 0;
      m_lines = 0;
    end
    drive_line(0, 1'b1, -1);
    for (int row = 0; row < V; row++) begin
      if (row == vs_row) begin
        drive_line(0, 1'b0, -1);
        drive_line(0, 1'b0, -1);
        return;
      end
      if (row == arm_row) pulse(1'b1, 1'b0);
      if (row == abort_row) pulse(1'b0, 1'b1);
      drive_line((row == short_row) ? H - 1 : H, 1'b1, (row == reset_row) ? H / 2 : -1);
    end
    drive_line(0, 1'b1, -1);
  endtask

  task automatic check_flags(input string tag);
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_busy"}, int'(busy), int'(cap_on || cap_pending));
    check({tag, "_done"}, int'(done), int'(m_done));
    check({tag, "_line_err"}, int'(line_err), int'(m_lerr));
    check({tag, "_frame_err"}, int'(frame_err), int'(m_ferr));
    check({tag, "_lines"}, int'(lines_captured), m_lines);
    check({tag, "_pending_writes"}, exp_q.size(), 0);
  endtask

  initial begin
    #23;
    check_outputs_zero();
    @(posedge clk); #1;
    reset_n = 1'b1;

    pulse(1'b1, 1'b1);                 // abort beats arm

    cmode = 1;                         // gray ramp, nominal frame
    pulse(1'b1, 1'b0);
    drive_frame(-1, -1, -1, -1, -1);
    check_flags("nominal");

    cmode = 2;                         // pure red; arm during capture is ignored
    pulse(1'b1, 1'b0);
    drive_frame(-1, -1, 2, -1, -1);
    check_flags("red");

    cmode = 3;                         // constant colour with one short line
    pulse(1'b1, 1'b0);
    drive_frame(3, -1, -1, -1, -1);
    check_flags("short_line");

    cmode = 0;                         // arm mid-frame, capture the following frame
    drive_frame(-1, -1, 2, -1, -1);
    check_flags("midframe_wait");
    drive_frame(-1, -1, -1, -1, -1);
    check_flags("midframe_cap");

    pulse(1'b1, 1'b0);                 // early vsync
    drive_frame(-1, 3, -1, -1, -1);
    check_flags("early_vs");

    pulse(1'b1, 1'b0);                 // abort partway
    drive_frame(-1, -1, -1, 2, -1);
    check_flags("abort");

    pulse(1'b1, 1'b0);                 // re-arm after abort
    drive_frame(-1, -1, -1, -1, -1);
    check_flags("rearm");

    pulse(1'b1, 1'b0);                 // reset mid-line
    drive_frame(-1, -1, -1, -1, 2);
    check_flags("reset_mid");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
